// File: rtl/rr_req_arbiter16_if.sv
// Request/grant bundle between the round-robin arbiter and its requesters and encoder.
interface rr_req_arbiter16_if;
    localparam int unsigned NREQ = 16;
    localparam int unsigned CNTW = 5;

    logic [NREQ-1:0] req;
    logic            grant_ready;
    logic [NREQ-1:0] grant;
    logic            grant_en;
    logic [NREQ-1:0] pending;
    logic [CNTW-1:0] pend_cnt;
    logic            ovf;

    // Arbiter side
    modport master (
        input  req, grant_ready,
        output grant, grant_en, pending, pend_cnt, ovf
    );

    // Requester / encoder side
    modport slave (
        output req, grant_ready,
        input  grant, grant_en, pending, pend_cnt, ovf
    );
endinterface

// File: rtl/rr_req_arbiter16.sv
// Sticky-pending round-robin arbiter feeding a 16-to-4 encoder with a registered one-hot grant.
module rr_req_arbiter16 (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_req_arbiter16_if.master   bus
);
    localparam int unsigned NREQ = 16;
    localparam int unsigned PTRW = 4;
    localparam int unsigned CNTW = 5;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [PTRW-1:0] ptr_q, ptr_d;

    logic            accept_c;
    logic [NREQ-1:0] clr_c;
    logic [NREQ-1:0] cand_c;
    logic [PTRW-1:0] gidx_c;
    logic [PTRW-1:0] start_c;
    logic [NREQ-1:0] pick_c;

    // Lowest set bit of c at or above start, wrapping; result is one-hot or zero.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] c,
                                                input logic [PTRW-1:0] start);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        logic [NREQ-1:0]   first;
        logic [2*NREQ-1:0] back;
        dbl   = {c, c} >> start;
        rot   = dbl[NREQ-1:0];
        first = rot & (~rot + NREQ'(1));
        back  = {first, first} << start;
        return back[2*NREQ-1:NREQ];
    endfunction

    always_comb begin
        accept_c = (state_q == GRANT) & bus.grant_ready;
        clr_c    = accept_c ? grant_q : '0;
        cand_c   = pending_q & ~grant_q;
    end

    // Grant is one-hot, so OR-ing indices recovers its position.
    always_comb begin
        gidx_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) gidx_c = gidx_c | PTRW'(i);
        end
    end

    always_comb begin
        pending_d = (pending_q & ~clr_c) | bus.req;
        ovf_d     = ovf_q | (|(bus.req & pending_q & ~clr_c));
        cnt_d     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cnt_d = cnt_d + CNTW'(pending_d[i]);
        end
        ptr_d   = accept_c ? (gidx_c + PTRW'(1)) : ptr_q;
        start_c = ptr_d;
        pick_c  = rr_pick(cand_c, start_c);
    end

    // Next-state and next grant; grant only changes from IDLE or on accept.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (|cand_c) begin
                    grant_d = pick_c;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept_c) begin
                    if (|cand_c) begin
                        grant_d = pick_c;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_en = (state_q == GRANT);
    assign bus.pending  = pending_q;
    assign bus.pend_cnt = cnt_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_rr_req_arbiter16.sv
// Directed bench for rr_req_arbiter16 with hand-computed expectations.
module tb_rr_req_arbiter16;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rr_req_arbiter16_if bus();

    rr_req_arbiter16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [15:0] g, input logic en,
                              input logic [15:0] p, input logic [4:0] c, input logic o);
        chk({tag, ".grant"},    32'(bus.grant),    32'(g));
        chk({tag, ".grant_en"}, 32'(bus.grant_en), 32'(en));
        chk({tag, ".pending"},  32'(bus.pending),  32'(p));
        chk({tag, ".pend_cnt"}, 32'(bus.pend_cnt), 32'(c));
        chk({tag, ".ovf"},      32'(bus.ovf),      32'(o));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.req         = '0;
        bus.grant_ready = 1'b0;
        #3;
        expect_all("reset", 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b0);
        rst_n = 1'b1;

        // Single request, ptr moves to 6
        bus.req = 16'h0020; bus.grant_ready = 1'b1;
        tick(); expect_all("single.e1", 16'h0000, 1'b0, 16'h0020, 5'd1, 1'b0);
        bus.req = '0;
        tick(); expect_all("single.e2", 16'h0020, 1'b1, 16'h0020, 5'd1, 1'b0);
        tick(); expect_all("single.e3", 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b0);

        // Reset asserted mid-grant drops everything before any edge
        bus.req = 16'h0020; bus.grant_ready = 1'b0;
        tick(); bus.req = '0;
        tick(); expect_all("pre_rst", 16'h0020, 1'b1, 16'h0020, 5'd1, 1'b0);
        rst_n = 1'b0;
        #2;
        expect_all("mid_rst", 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b0);
        #2;
        rst_n = 1'b1;

        // Round-robin wrap from ptr=0
        bus.req = 16'h8003; bus.grant_ready = 1'b1;
        tick(); expect_all("wrap.e1", 16'h0000, 1'b0, 16'h8003, 5'd3, 1'b0);
        bus.req = '0;
        tick(); expect_all("wrap.e2", 16'h0001, 1'b1, 16'h8003, 5'd3, 1'b0);
        tick(); expect_all("wrap.e3", 16'h0002, 1'b1, 16'h8002, 5'd2, 1'b0);
        tick(); expect_all("wrap.e4", 16'h8000, 1'b1, 16'h8000, 5'd1, 1'b0);
        bus.req = 16'h0001;
        tick(); expect_all("wrap.e5", 16'h0000, 1'b0, 16'h0001, 5'd1, 1'b0);
        bus.req = '0;
        tick(); expect_all("wrap.e6", 16'h0001, 1'b1, 16'h0001, 5'd1, 1'b0);
        tick(); expect_all("wrap.e7", 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b0);

        // Backpressure with ptr=1: grant holds, then search from 3 wraps to 0
        bus.req = 16'h0004; bus.grant_ready = 1'b0;
        tick(); expect_all("bp.e1", 16'h0000, 1'b0, 16'h0004, 5'd1, 1'b0);
        bus.req = '0;
        tick(); expect_all("bp.e2", 16'h0004, 1'b1, 16'h0004, 5'd1, 1'b0);
        bus.req = 16'h0001;
        tick(); expect_all("bp.e3", 16'h0004, 1'b1, 16'h0005, 5'd2, 1'b0);
        bus.req = '0;
        tick(); expect_all("bp.e4", 16'h0004, 1'b1, 16'h0005, 5'd2, 1'b0);
        tick(); expect_all("bp.e5", 16'h0004, 1'b1, 16'h0005, 5'd2, 1'b0);
        tick(); expect_all("bp.e6", 16'h0004, 1'b1, 16'h0005, 5'd2, 1'b0);
        bus.grant_ready = 1'b1;
        tick(); expect_all("bp.e7", 16'h0001, 1'b1, 16'h0001, 5'd1, 1'b0);
        tick(); expect_all("bp.e8", 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b0);

        // Re-arm: request on the line being accepted stays pending, no ovf
        bus.req = 16'h0010;
        tick(); expect_all("rearm.e1", 16'h0000, 1'b0, 16'h0010, 5'd1, 1'b0);
        bus.req = '0;
        tick(); expect_all("rearm.e2", 16'h0010, 1'b1, 16'h0010, 5'd1, 1'b0);
        bus.req = 16'h0010;
        tick(); expect_all("rearm.e3", 16'h0000, 1'b0, 16'h0010, 5'd1, 1'b0);
        bus.req = '0;
        tick(); expect_all("rearm.e4", 16'h0010, 1'b1, 16'h0010, 5'd1, 1'b0);
        tick(); expect_all("rearm.e5", 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b0);

        // Overflow: second request on a pending, unaccepted line; sticky
        bus.req = 16'h0010; bus.grant_ready = 1'b0;
        tick(); expect_all("ovf.e1", 16'h0000, 1'b0, 16'h0010, 5'd1, 1'b0);
        tick(); expect_all("ovf.e2", 16'h0010, 1'b1, 16'h0010, 5'd1, 1'b1);
        bus.req = '0;
        tick(); expect_all("ovf.e3", 16'h0010, 1'b1, 16'h0010, 5'd1, 1'b1);
        bus.grant_ready = 1'b1;
        tick(); expect_all("ovf.e4", 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b1);

        // All 16 lines from ptr=5: back-to-back one-hot grants in index order
        bus.req = 16'hFFFF;
        tick(); chk("all.load_cnt", 32'(bus.pend_cnt), 32'd16);
        chk("all.load_en", 32'(bus.grant_en), 32'd0);
        bus.req = '0;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] eg;
            tick();
            eg = 16'h0001 << ((5 + i) % 16);
            chk($sformatf("all.grant%0d", i), 32'(bus.grant), 32'(eg));
            chk($sformatf("all.cnt%0d", i), 32'(bus.pend_cnt), 32'(16 - i));
            chk($sformatf("all.onehot%0d", i), 32'($onehot(bus.grant)), 32'd1);
        end
        tick(); expect_all("all.end", 16'h0000, 1'b0, 16'h0000, 5'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
